// File: rtl/rr_sel_arbiter_pkg.sv
// arb_pkg: shared state encoding, default sizing and one-hot helper for the round-robin arbiter.
package arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int LOCK_MAX_DEF = 4;
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (oh[i]) r = r | 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request vector plus one-hot grant offered over a valid/ready handshake.
interface rr_sel_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_ready;
  modport master (input req, gnt_ready, output gnt, gnt_idx, gnt_valid);
  modport slave  (output req, gnt_ready, input gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: first set request at or above ptr with wrap-around (rotate, find-first, rotate back).
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] pick_idx,
  output logic [N_REQ-1:0] pick_oh
);
  logic [N_REQ-1:0] rot, first;
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) rot[i] = req[IDX_W'((i + int'(ptr)) % N_REQ)];
  end
  assign first = rot & (~rot + 1'b1);
  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < N_REQ; i++) pick_oh[IDX_W'((i + int'(ptr)) % N_REQ)] = first[i];
  end
  assign any = |req;
  assign pick_idx = IDX_W'(onehot_to_idx(16'(pick_oh)));
endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter with frozen one-hot offer until handshake.
// Optional burst lock enabled by defining ARB_LOCK_EN.
module rr_sel_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ),
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input logic clk,
  input logic rst,
  rr_sel_arbiter_if.master a
);
  state_t           state_q;
  logic [IDX_W-1:0] ptr_q, idx_q, pick_idx, ptr_d;
  logic [N_REQ-1:0] gnt_q, pick_oh;
  logic             valid_q, any, hs;
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(a.req), .ptr(ptr_q), .any(any), .pick_idx(pick_idx), .pick_oh(pick_oh)
  );
  assign hs = valid_q & a.gnt_ready;
  assign ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
`ifdef ARB_LOCK_EN
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [CW-1:0] lock_cnt_q;
  logic          stay;
  assign stay = a.req[idx_q] && (lock_cnt_q < CW'(LOCK_MAX - 1));
  always_ff @(posedge clk)
    if (rst) lock_cnt_q <= '0;
    else if (state_q == ST_OFFER && hs) lock_cnt_q <= stay ? lock_cnt_q + 1'b1 : '0;
`else
  logic stay;
  assign stay = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (any) begin
        gnt_q   <= pick_oh;
        idx_q   <= pick_idx;
        valid_q <= 1'b1;
        state_q <= ST_OFFER;
      end
    end else if (hs && !stay) begin
      ptr_q   <= ptr_d;
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      state_q <= ST_IDLE;
    end
  end
  assign a.gnt = gnt_q;
  assign a.gnt_idx = idx_q;
  assign a.gnt_valid = valid_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rr_sel_arbiter;
  localparam int N = 4;
  localparam int LM = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  int m_ptr = 0, m_idx = 0, m_burst = 0;
  bit m_valid = 1'b0;
  rr_sel_arbiter_if #(.N_REQ(N), .IDX_W(2)) bus ();
  rr_sel_arbiter #(.N_REQ(N), .IDX_W(2), .LOCK_MAX(LM)) dut (.clk(clk), .rst(rst), .a(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_idx = 0; m_burst = 0;
    end else if (!m_valid) begin
      for (int k = 0; k < N; k++)
        if (!m_valid && bus.req[(m_ptr + k) % N]) begin
          m_idx = (m_ptr + k) % N;
          m_valid = 1;
        end
    end else if (bus.gnt_ready) begin
      if (LOCK && bus.req[m_idx] && m_burst < LM - 1) m_burst++;
      else begin
        m_ptr = (m_idx + 1) % N; m_valid = 0; m_burst = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(bus.gnt), m_valid ? 32'(1) << m_idx : 32'd0);
    chk("gnt_idx", 32'(bus.gnt_idx), m_valid ? 32'(m_idx) : 32'd0);
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
    chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic rdy);
    rst = r; bus.req = q; bus.gnt_ready = rdy;
  endtask

  initial begin
    drive(1, 4'b1111, 0);
    for (int i = 0; i < 3; i++) cyc();
    // all-request rotation with ready held high
    drive(0, 4'b1111, 1);
    for (int i = 0; i < 12; i++) cyc();
    // offer held stable while ready is low, even after the request drops
    drive(1, 4'b0000, 0); cyc();
    drive(0, 4'b0100, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.req = 4'b0000;
      cyc();
      chk("hold_gnt", 32'(bus.gnt), 32'h4);
      chk("hold_valid", 32'(bus.gnt_valid), 32'd1);
    end
    bus.gnt_ready = 1; cyc();
    chk("hs_drop", 32'(bus.gnt_valid), 32'd0);
    // ptr now 3: grant 3 then wrap to 0
    bus.req = 4'b1001; cyc();
    chk("wrap_first", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0001; cyc();
    cyc();
    chk("wrap_second", 32'(bus.gnt), 32'h1);
    // reset during an accepted offer credits nothing
    drive(1, 4'b0000, 0); cyc();
    drive(0, 4'b0010, 0); cyc();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h2);
    drive(1, 4'b0010, 1); cyc();
    chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
    drive(0, 4'b1111, 0); cyc();
    chk("rst_ptr", 32'(bus.gnt), 32'h1);
    // two-requester burst behaviour
    drive(1, 4'b0000, 0); cyc();
    drive(0, 4'b0011, 1);
    for (int i = 0; i < 14; i++) cyc();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 2) != 0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
